result_monitor: RTL

// Scoreboard stage directly downstream of the stimulus driver. Consumes the

---
 rtl/result_monitor_pkg.sv | 22 ++
 rtl/result_monitor_if.sv | 33 +++
 rtl/result_monitor_ref_model.sv | 24 ++
 rtl/result_monitor.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/result_monitor_pkg.sv
// Shared definitions for the result monitor and the stimulus driver.
package result_monitor_pkg;

  // Reference operation codes
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;

  // One-hot monitor states
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_WAIT   = 5'b00010,
    ST_SETTLE = 5'b00100,
    ST_CHECK  = 5'b01000,
    ST_DONE   = 5'b10000
  } state_t;

  // Driver reports an all-ones delay until the DUT latency has been measured.
  // Wide enough for any operand width up to 64; users slice the low bits.
  localparam logic [63:0] DELAY_UNKNOWN = '1;

endpackage

// File: rtl/result_monitor_if.sv
// Handshake/result bundle between the stimulus driver (master) and the
// result monitor (slave).
interface result_monitor_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [WIDTH-1:0] i_dut_delay;
  logic [WIDTH-1:0] i_check_a;
  logic [WIDTH-1:0] i_check_b;
  logic             i_sample_valid;
  logic [WIDTH-1:0] i_dut_out;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic [WIDTH-1:0] o_latency;
  logic [31:0]      o_sample_count;
  logic [15:0]      o_err_count;
  logic [WIDTH-1:0] o_first_err_a;
  logic [WIDTH-1:0] o_first_err_b;
  logic [WIDTH-1:0] o_first_err_out;

  modport master (
    output i_start, i_dut_delay, i_check_a, i_check_b, i_sample_valid, i_dut_out,
    input  o_busy, o_done, o_pass, o_latency, o_sample_count, o_err_count,
           o_first_err_a, o_first_err_b, o_first_err_out
  );

  modport slave (
    input  i_start, i_dut_delay, i_check_a, i_check_b, i_sample_valid, i_dut_out,
    output o_busy, o_done, o_pass, o_latency, o_sample_count, o_err_count,
           o_first_err_a, o_first_err_b, o_first_err_out
  );
endinterface

// File: rtl/result_monitor_ref_model.sv
// Combinational reference operation used to recompute the expected DUT result.
module result_monitor_ref_model
  import result_monitor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP    = OP_ADD
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // Select the reference op; sub wraps naturally, and a WIDTH-wide multiply
  // yields exactly the low half of the full 2*WIDTH product.
  always_comb begin
    result = a + b;
    if (OP == OP_SUB) begin
      result = a - b;
    end else if (OP == OP_MUL) begin
      result = a * b;
    end
  end

endmodule

// File: rtl/result_monitor.sv
// Scoreboard stage: waits for the DUT latency, flushes the pipeline, then
// compares every valid sample against the reference model for a fixed run.
module result_monitor
  import result_monitor_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int OP       = OP_ADD,
  parameter int RUN_LOG2 = 16,
  parameter int SETTLE   = 4
) (
  input logic              clk_dut,
  input logic              reset_n,
  result_monitor_if.slave  bus
);

  localparam int                CNT_W       = RUN_LOG2 + 1;
  localparam logic [CNT_W-1:0]  RUN_LAST    = {1'b0, {RUN_LOG2{1'b1}}};
  localparam int                SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0]  ONES        = '1;

  state_t             state;
  logic [SET_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]   qual_cnt;
  logic [WIDTH-1:0]   latency;
  logic [WIDTH-1:0]   expected;
  logic               qual;
  logic               start_ok;
  logic               delay_known;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_exp;
  logic [WIDTH-1:0]   s1_out;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;

  logic [31:0]        sample_count;
  logic [15:0]        err_count;
  logic [WIDTH-1:0]   first_a;
  logic [WIDTH-1:0]   first_b;
  logic [WIDTH-1:0]   first_out;

  result_monitor_ref_model #(.WIDTH(WIDTH), .OP(OP)) u_ref (
    .a      (bus.i_check_a),
    .b      (bus.i_check_b),
    .result (expected)
  );

  assign start_ok    = bus.i_start && (state == ST_IDLE || state == ST_DONE);
  assign delay_known = (bus.i_dut_delay != DELAY_UNKNOWN[WIDTH-1:0]);
  assign qual        = (state == ST_CHECK) && bus.i_sample_valid;

  // Run sequencing: latch latency, flush for SETTLE cycles, count qualified samples
  always_ff @(posedge clk_dut or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      qual_cnt   <= '0;
      latency    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            state    <= ST_WAIT;
            qual_cnt <= '0;
            latency  <= '0;
          end
        end
        ST_WAIT: begin
          if (delay_known) begin
            state      <= ST_SETTLE;
            latency    <= bus.i_dut_delay;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          if (bus.i_sample_valid) begin
            qual_cnt <= qual_cnt + 1'b1;
            if (qual_cnt == RUN_LAST) begin
              state <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: register expected result, DUT output, operands and qualifier
  always_ff @(posedge clk_dut or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_exp   <= '0;
      s1_out   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= qual;
      s1_exp   <= expected;
      s1_out   <= bus.i_dut_out;
      s1_a     <= bus.i_check_a;
      s1_b     <= bus.i_check_b;
    end
  end

  // Stage 2: compare and update saturating counters; a new run start wins
  always_ff @(posedge clk_dut or negedge reset_n) begin
    if (!reset_n) begin
      sample_count <= '0;
      err_count    <= '0;
      first_a      <= ONES;
      first_b      <= ONES;
      first_out    <= ONES;
    end else if (start_ok) begin
      sample_count <= '0;
      err_count    <= '0;
      first_a      <= ONES;
      first_b      <= ONES;
      first_out    <= ONES;
    end else if (s1_valid) begin
      if (sample_count != '1) begin
        sample_count <= sample_count + 1'b1;
      end
      if (s1_exp != s1_out) begin
        if (err_count != 16'hFFFF) begin
          err_count <= err_count + 1'b1;
        end
        if (err_count == 16'h0000) begin
          first_a   <= s1_a;
          first_b   <= s1_b;
          first_out <= s1_out;
        end
      end
    end
  end

  assign bus.o_busy          = (state == ST_WAIT) || (state == ST_SETTLE) || (state == ST_CHECK);
  assign bus.o_done          = (state == ST_DONE);
  assign bus.o_pass          = (state == ST_DONE) && (err_count == 16'h0000);
  assign bus.o_latency       = latency;
  assign bus.o_sample_count  = sample_count;
  assign bus.o_err_count     = err_count;
  assign bus.o_first_err_a   = first_a;
  assign bus.o_first_err_b   = first_b;
  assign bus.o_first_err_out = first_out;

endmodule
